// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default sizes for the CDB arbiter.
// Types: cdb_entry_t (one completion), cdb_t (one CDB broadcast), cdb_buf_ptr_t.
// Defaults: ALU_RS_SIZE=8, NUM_CDB_ENTRIES=4, CDB_BUF_DEPTH=16 (overridable by define).
`ifndef ALU_RS_SIZE
`define ALU_RS_SIZE 8
`endif
`ifndef NUM_CDB_ENTRIES
`define NUM_CDB_ENTRIES 4
`endif
`ifndef CDB_BUF_DEPTH
`define CDB_BUF_DEPTH 16
`endif

package cdb_arbiter_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    // Tag 0 is reserved and marks an idle/invalid entry.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cdb_entry_t;

    typedef cdb_entry_t [`NUM_CDB_ENTRIES-1:0] cdb_t;

    typedef logic [$clog2(`CDB_BUF_DEPTH)-1:0] cdb_buf_ptr_t;

    function automatic logic entry_valid(input cdb_entry_t e);
        return e.tag != '0;
    endfunction

endpackage

// File: rtl/cdb_compact.sv
// Packs valid completions (tag != 0) to the low indices, preserving index order.
// Purely combinational: zero latency.
// Ports: in_vals (raw RS completions), packed_vals (compacted, zero-filled), n_in (valid count).
module cdb_compact
    import cdb_arbiter_pkg::*;
#(
    parameter int IN_N = `ALU_RS_SIZE
) (
    input  cdb_entry_t [IN_N-1:0]          in_vals,
    output cdb_entry_t [IN_N-1:0]          packed_vals,
    output logic [$clog2(IN_N+1)-1:0]      n_in
);

    localparam int NW = $clog2(IN_N + 1);

    // Constant-index mux per output slot: slot k takes the entry whose
    // running valid count equals k.
    always_comb begin
        int pos;
        pos         = 0;
        packed_vals = '0;
        for (int i = 0; i < IN_N; i++) begin
            if (entry_valid(in_vals[i])) begin
                for (int k = 0; k < IN_N; k++) begin
                    if (k == pos) begin
                        packed_vals[k] = in_vals[i];
                    end
                end
                pos++;
            end
        end
        n_in = NW'(pos);
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers ALU RS completions in age/index order and broadcasts up to OUT_N per cycle on the CDB.
// Latency: 1 cycle with CDB_ARB_BYPASS_EN defined (empty buffer), otherwise 2 cycles minimum.
// No input backpressure: cdb_almost_full warns the decoder; excess entries are dropped and flagged sticky in cdb_overflow.
// Ports: clk, rst (async, active-high), flush (sync squash), cdb_alu_vals_i (IN_N completions),
//        cdb_vals_o (registered OUT_N slots, tag 0 = idle), cdb_almost_full, cdb_overflow.
// Macro: CDB_ARB_BYPASS_EN lets same-cycle inputs go straight to free output slots.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int IN_N  = `ALU_RS_SIZE,
    parameter int OUT_N = `NUM_CDB_ENTRIES,
    parameter int DEPTH = `CDB_BUF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  cdb_entry_t [IN_N-1:0]   cdb_alu_vals_i,
    output cdb_entry_t [OUT_N-1:0]  cdb_vals_o,
    output logic                    cdb_almost_full,
    output logic                    cdb_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(IN_N + 1);

    cdb_entry_t [IN_N-1:0]  in_packed;
    logic [NW-1:0]          n_in;

    cdb_compact #(.IN_N(IN_N)) u_compact (
        .in_vals     (cdb_alu_vals_i),
        .packed_vals (in_packed),
        .n_in        (n_in)
    );

    cdb_entry_t             buf_q [DEPTH];
    logic [PW-1:0]          head_q;
    logic [PW-1:0]          tail_q;
    logic [CW-1:0]          count_q;

    int                     n_from_buf;
    int                     n_from_in;
    int                     n_store;
    cdb_entry_t [OUT_N-1:0] vals_next;
    logic [CW-1:0]          count_next;
    logic                   af_next;
    logic                   ovf_next;
    logic [DEPTH-1:0]       wr_en;
    cdb_entry_t             wr_dat [DEPTH];

    always_comb begin
        int            cnt;
        int            nin;
        int            left;
        int            space;
        int            cnt_n;
        logic [PW-1:0] widx;
        cdb_entry_t    sel;

        cnt   = int'(count_q);
        nin   = int'(n_in);
        widx  = '0;
        sel   = '0;

        // Buffered entries are always older, so they claim output slots first.
        n_from_buf = (cnt < OUT_N) ? cnt : OUT_N;
`ifdef CDB_ARB_BYPASS_EN
        n_from_in  = ((OUT_N - n_from_buf) < nin) ? (OUT_N - n_from_buf) : nin;
`else
        n_from_in  = 0;
`endif
        left  = nin - n_from_in;
        // Entries popped this cycle free their slots for this cycle's pushes.
        space   = DEPTH - cnt + n_from_buf;
        n_store = (left < space) ? left : space;
        ovf_next = left > space;

        cnt_n      = cnt - n_from_buf + n_store;
        count_next = CW'(cnt_n);
        af_next    = cnt_n > (DEPTH - IN_N);

        vals_next = '0;
        for (int s = 0; s < OUT_N; s++) begin
            if (s < n_from_buf) begin
                vals_next[s] = buf_q[head_q + PW'(s)];
            end else begin
                for (int k = 0; k < IN_N; k++) begin
                    if ((k == s - n_from_buf) && (k < n_from_in)) begin
                        vals_next[s] = in_packed[k];
                    end
                end
            end
        end

        // Leftover compacted entries land at tail in order; the highest-index
        // ones are the ones cut off when space runs out.
        wr_en = '0;
        for (int d = 0; d < DEPTH; d++) begin
            wr_dat[d] = '0;
        end
        for (int j = 0; j < IN_N; j++) begin
            if (j < n_store) begin
                widx = tail_q + PW'(j);
                sel  = '0;
                for (int k = 0; k < IN_N; k++) begin
                    if (k == n_from_in + j) begin
                        sel = in_packed[k];
                    end
                end
                wr_en[widx]  = 1'b1;
                wr_dat[widx] = sel;
            end
        end
    end

    // Storage needs no reset: validity is carried entirely by head/count.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int d = 0; d < DEPTH; d++) begin
                if (wr_en[d]) begin
                    buf_q[d] <= wr_dat[d];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            cdb_vals_o      <= '0;
            cdb_almost_full <= 1'b0;
            cdb_overflow    <= 1'b0;
        end else if (flush) begin
            // Overflow is an error record and survives a squash.
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            cdb_vals_o      <= '0;
            cdb_almost_full <= 1'b0;
        end else begin
            head_q          <= head_q + PW'(n_from_buf);
            tail_q          <= tail_q + PW'(n_store);
            count_q         <= count_next;
            cdb_vals_o      <= vals_next;
            cdb_almost_full <= af_next;
            if (ovf_next) begin
                cdb_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed stimulus for cdb_arbiter, checked against a queue-based reference model.
// The model follows the ordering rules directly: oldest buffered first, then valid inputs by index.
// Works with CDB_ARB_BYPASS_EN either defined or undefined.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int IN_N  = 8;
    localparam int OUT_N = 4;
    localparam int DEPTH = 16;

`ifdef CDB_ARB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    cdb_entry_t [IN_N-1:0]  vin;
    cdb_entry_t [OUT_N-1:0] vout;
    logic                   afull;
    logic                   ovf;

    cdb_arbiter #(.IN_N(IN_N), .OUT_N(OUT_N), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .cdb_alu_vals_i  (vin),
        .cdb_vals_o      (vout),
        .cdb_almost_full (afull),
        .cdb_overflow    (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    cdb_entry_t mq[$];
    cdb_entry_t m_out [OUT_N];
    bit         m_af;
    bit         m_ovf;
    int         tag_ctr;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [TAG_W-1:0] next_tag();
        tag_ctr = (tag_ctr % 63) + 1;
        return TAG_W'(tag_ctr);
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int s = 0; s < OUT_N; s++) m_out[s] = '0;
        m_af  = 1'b0;
        m_ovf = 1'b0;
    endtask

    // One clock of the reference: sequence = buffered (+ inputs when bypassing),
    // broadcast the head of the sequence, keep the rest up to DEPTH entries.
    task automatic model_step();
        cdb_entry_t inq[$];
        cdb_entry_t seq[$];
        int n;
        if (flush) begin
            mq.delete();
            for (int s = 0; s < OUT_N; s++) m_out[s] = '0;
            m_af = 1'b0;
            return;
        end
        for (int i = 0; i < IN_N; i++)
            if (vin[i].tag != '0) inq.push_back(vin[i]);
        seq = mq;
        if (BYPASS) foreach (inq[i]) seq.push_back(inq[i]);
        n = (seq.size() < OUT_N) ? seq.size() : OUT_N;
        for (int s = 0; s < OUT_N; s++) m_out[s] = '0;
        for (int s = 0; s < n; s++) m_out[s] = seq.pop_front();
        if (!BYPASS) foreach (inq[i]) seq.push_back(inq[i]);
        mq.delete();
        foreach (seq[i]) begin
            if (mq.size() < DEPTH) mq.push_back(seq[i]);
            else m_ovf = 1'b1;
        end
        m_af = mq.size() > (DEPTH - IN_N);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        for (int s = 0; s < OUT_N; s++)
            check_eq($sformatf("slot%0d", s), 64'(vout[s]), 64'(m_out[s]));
        check_eq("almost_full", 64'(afull), 64'(m_af));
        check_eq("overflow", 64'(ovf), 64'(m_ovf));
    endtask

    task automatic set_mask(input logic [IN_N-1:0] mask);
        for (int i = 0; i < IN_N; i++) begin
            if (mask[i]) begin
                vin[i].tag   = next_tag();
                vin[i].value = $urandom;
            end else begin
                vin[i] = '0;
            end
        end
    endtask

    task automatic idle(input int n);
        vin = '0;
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #12;
        check_eq("rst_vals", 64'(vout != '0), 64'(0));
        check_eq("rst_afull", 64'(afull), 64'(0));
        check_eq("rst_ovf", 64'(ovf), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        flush   = 1'b0;
        vin     = '0;
        tag_ctr = 0;
        model_reset();
        do_reset();
        @(posedge clk);
        #1;

        // Single input at index 5: latency 1 with bypass, 2 without.
        vin[5].tag   = 6'd3;
        vin[5].value = 32'h10;
        cycle();
        check_eq("s1_cyc1_tag", 64'(vout[0].tag), BYPASS ? 64'd3 : 64'd0);
        vin = '0;
        cycle();
        check_eq("s1_cyc2_tag", 64'(vout[0].tag), BYPASS ? 64'd0 : 64'd3);
        check_eq("s1_cyc2_val", 64'(vout[0].value), BYPASS ? 64'd0 : 64'h10);
        idle(2);

        // Full burst: tags 1..8 in one cycle.
        tag_ctr = 0;
        set_mask(8'hFF);
        cycle();
        idle(4);

        // Three bursts of 8: almost-full rises, order 1..24, nothing lost.
        tag_ctr = 0;
        for (int c = 0; c < 3; c++) begin
            set_mask(8'hFF);
            cycle();
        end
        idle(7);
        check_eq("s3_no_ovf", 64'(ovf), 64'(0));

        // Saturate until the buffer overflows, then flush with inputs present.
        for (int c = 0; c < 5; c++) begin
            set_mask(8'hFF);
            cycle();
        end
        set_mask(8'h07);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle(3);
        check_eq("s4_ovf_sticky", 64'(ovf), 64'(1));

        // Flush with a partly filled buffer plus new inputs.
        set_mask(8'hFF); cycle();
        set_mask(8'hFF); cycle();
        set_mask(8'h3F); cycle();
        set_mask(8'h0B);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle(3);

        // Asynchronous reset in the middle of a cycle with buffered data.
        set_mask(8'hFF); cycle();
        set_mask(8'hFF);
        model_step();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_vals", 64'(vout != '0), 64'(0));
        check_eq("arst_afull", 64'(afull), 64'(0));
        check_eq("arst_ovf", 64'(ovf), 64'(0));
        model_reset();
        vin = '0;
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Randomized traffic with varying density and occasional flush.
        for (int c = 0; c < 400; c++) begin
            logic [IN_N-1:0] m;
            case ((c / 50) % 4)
                0: m = IN_N'($urandom & $urandom);
                1: m = IN_N'($urandom);
                2: m = IN_N'($urandom | $urandom);
                default: m = IN_N'($urandom & $urandom & $urandom);
            endcase
            set_mask(m);
            flush = ($urandom_range(0, 39) == 0);
            cycle();
        end
        flush = 1'b0;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Sits between the ALU reservation stations and the common data bus (CDB).
- Every cycle the ALU RS may emit one completion per entry, with no backpressure. This block buffers those completions in age/index order and drives at most `NUM_CDB_ENTRIES` broadcasts per cycle onto the CDB.
- Its outputs feed the ROB and every RS's tag-match logic.
- It gives the decoder an early-warning signal so issue stops before the buffer can overflow.

## Interface

- `IN_N`, default `` `ALU_RS_SIZE `` (8): completion inputs per cycle.
- `OUT_N`, default `` `NUM_CDB_ENTRIES ``: CDB slots per cycle.
- `DEPTH`, default `` `CDB_BUF_DEPTH `` (16): buffer entries; must be a power of 2 and ≥ 2·`IN_N`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous squash from branch mispredict.
- `cdb_alu_vals_i` in `cdb_entry_t [IN_N]`: completions from the ALU RS; an entry is valid iff `tag != 0` (tag 0 is reserved).
- `cdb_vals_o` out `cdb_t` (`OUT_N` × `cdb_entry_t`): registered CDB broadcast; a slot with `tag == 0` is idle.
- `cdb_almost_full` out 1: registered; tells the decoder to stop issuing ALU ops.
- `cdb_overflow` out 1: sticky error flag.

## Operation

- **Storage:** a circular buffer of `DEPTH` `cdb_entry_t` with head/tail pointers of $clog2(`DEPTH`) bits that wrap modulo `DEPTH`, plus a count of $clog2(`DEPTH`)+1 bits.
- **Per-cycle ordering:**
  - Valid incoming entries are compacted in ascending index order.
  - The logical sequence is buffered entries (oldest first), then the compacted incoming entries.
- **Output selection:** the first min(`OUT_N`, available) entries of the sequence go to `cdb_vals_o` slots 0.., in order. Remaining slots are written `'0`.
- **Storing the rest:** leftover incoming entries are written at tail.
  - `count_next = count + n_in − n_out`.
  - `n_in` counts at most 0..`IN_N` entries; `n_out` at most `OUT_N`.
- **Overflow:** if leftover incoming entries exceed free space, the excess (highest-index) entries are dropped and `cdb_overflow` is set. It stays set until `rst`.
- **Almost full:** `cdb_almost_full` = registered (`count_next > DEPTH − IN_N`).
- **Flush:**
  - Next edge: count, pointers and `cdb_vals_o` are cleared, and `cdb_almost_full` goes to 0.
  - Entries arriving in the flush cycle are discarded.
  - `cdb_overflow` is not cleared by flush.
- **Reset (async):**
  - `cdb_vals_o` = all zeros; `cdb_almost_full` = 0; `cdb_overflow` = 0.
  - Pointers and count = 0.
  - Reset asserted mid-cycle discards all buffered state immediately.
- **Duplicate tags:** never filtered; the ROB guarantees uniqueness.

## Timing

- **Latency with bypass:** an input valid in cycle N appears on `cdb_vals_o` after the edge ending cycle N (1 cycle), provided buffer and output slots allow.
- **Latency without bypass:** see Configuration; minimum is 2 cycles.
- **Throughput:** `OUT_N` entries/cycle sustained.
- **Ordering:**
  - Older buffered entries always win over new entries.
  - Among same-cycle inputs, lower index wins.
- **Simultaneous push and pop at full:** the pop frees space in the same cycle, so space = `DEPTH − count + n_out`.
- **Broadcast duration:** each broadcast is held for exactly one cycle and is never repeated.
- **Almost-full lag:** `cdb_almost_full` lags occupancy by one cycle. The `IN_N` margin covers that lag.

## Configuration

- Macro: `CDB_ARB_BYPASS_EN`.
- **Defined:** behaviour as above; incoming entries can reach output slots in the same cycle (1-cycle latency when the buffer is empty).
- **Undefined:**
  - The logical sequence contains buffered entries only.
  - All incoming valid entries are pushed to the buffer.
  - Minimum latency is 2 cycles, and the compaction network is off the output path (shorter critical path).

## Structure

- `structs` package:
  - reuse `cdb_entry_t` and `cdb_t`;
  - add `cdb_buf_ptr_t`.
- `macros.sv`: add `` `CDB_BUF_DEPTH `` (16).
- Sub-module `cdb_compact`: a combinational network that packs the `IN_N` valid entries to the low indices and returns the count `n_in`.
- Everything else (pointers, output register, flags) stays in `cdb_arbiter`.

## Test plan

All scenarios use `IN_N`=8, `OUT_N`=4, `DEPTH`=16, bypass enabled unless stated.

1. **Single input:** one input at index 5 with tag 3, value 0x10 → next cycle slot 0 = {tag 3, value 0x10}; slots 1–3 tag 0; count 0.
2. **Full burst:** 8 valid inputs (tags 1–8) in one cycle → cycle+1 broadcasts tags 1–4; cycle+2 broadcasts 5–8; count returns to 0.
3. **Almost full:** 8 inputs per cycle for 3 cycles → `cdb_almost_full` rises once count > 8. Output order strictly by tag 1..24; no entries lost.
4. **Overflow:** buffer at 14 with no pop possible (saturate 4/cycle) plus 8 new entries → excess dropped; `cdb_overflow` = 1 and stays 1 through a later flush.
5. **Flush and reset:**
   - `flush` with 10 buffered entries plus 3 inputs → next cycle all slots idle, count 0, nothing ever broadcast.
   - Async `rst` mid-cycle → outputs zero immediately.
6. **Bypass compiled out:** with `CDB_ARB_BYPASS_EN` undefined, the scenario 1 input appears 2 cycles later, not 1.
